// File: rtl/rotary_value_accumulator.sv
// rotary_value_accumulator
// Turns single-cycle quadrature step strobes into a bounded, registered
// user value with saturate or wrap limits, a synchronous load and
// two-level acceleration for fast same-direction rotation.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_cnt          step strobe, one cycle per detent
//   i_cnt_cw       step direction (1 = up), qualified by i_cnt
//   i_load         synchronous load request, wins over i_cnt
//   i_load_value   value to load, clamped into [MIN, MAX]
//   o_value        current value
//   o_changed      one-cycle pulse when o_value changed on the previous edge
//   o_at_min       o_value == MIN
//   o_at_max       o_value == MAX
module rotary_value_accumulator #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MIN         = 0,
    parameter int unsigned MAX         = 255,
    parameter int unsigned RESET_VALUE = 0,
    parameter int unsigned WRAP        = 0,
    parameter int unsigned FAST_GAP    = 1000,
    parameter int unsigned ACCEL_AFTER = 3,
    parameter int unsigned FAST_STEP   = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cnt,
    input  logic             i_cnt_cw,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_value,
    output logic             o_changed,
    output logic             o_at_min,
    output logic             o_at_max
);

    // Arithmetic width: two guard bits keep value +/- FAST_STEP from overflowing.
    localparam int unsigned AW = WIDTH + 2;
    // Gap counter must hold FAST_GAP+1 (the "slow" saturation value).
    localparam int unsigned GW = $clog2(FAST_GAP + 2);
    localparam int unsigned SW = $clog2(ACCEL_AFTER + 1);

    localparam logic [GW-1:0]        GAP_SLOW   = GW'(FAST_GAP + 1);
    localparam logic [GW-1:0]        GAP_FAST   = GW'(FAST_GAP);
    localparam logic [SW-1:0]        STREAK_MAX = SW'(ACCEL_AFTER);
    localparam logic signed [AW-1:0] MIN_S      = AW'(MIN);
    localparam logic signed [AW-1:0] MAX_S      = AW'(MAX);
    localparam logic signed [AW-1:0] SPAN_S     = AW'(MAX - MIN + 1);
    localparam logic signed [AW-1:0] FAST_S     = AW'(FAST_STEP);
    localparam logic signed [AW-1:0] ONE_S      = AW'(1);
    localparam logic [WIDTH-1:0]     MIN_V      = WIDTH'(MIN);
    localparam logic [WIDTH-1:0]     MAX_V      = WIDTH'(MAX);
    localparam logic [WIDTH-1:0]     RESET_V    = WIDTH'(RESET_VALUE);

    logic [GW-1:0]    gap;
    logic [SW-1:0]    streak;
    logic             last_dir;

    logic [GW-1:0]    gap_next;
    logic [SW-1:0]    streak_next;
    logic             dir_next;
    logic [WIDTH-1:0] value_next;

    logic                 fast;
    logic [SW-1:0]        streak_step;
    logic signed [AW-1:0] load_ext;
    logic signed [AW-1:0] load_clamped;
    logic signed [AW-1:0] cur;
    logic signed [AW-1:0] delta;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] step_result;

    // Next-state: load > step > idle; gap/streak/direction tracking.
    always_comb begin
        gap_next     = (gap == GAP_SLOW) ? gap : gap + GW'(1);
        streak_next  = streak;
        dir_next     = last_dir;
        value_next   = o_value;
        fast         = 1'b0;
        streak_step  = '0;
        load_ext     = $signed({2'b00, i_load_value});
        load_clamped = load_ext;
        cur          = $signed({2'b00, o_value});
        delta        = ONE_S;
        sum          = cur;
        step_result  = cur;

        // Loads are clamped into range regardless of wrap mode.
        if (load_ext < MIN_S) begin
            load_clamped = MIN_S;
        end else if (load_ext > MAX_S) begin
            load_clamped = MAX_S;
        end

        // Fast means a recent step in the same direction; uses pre-edge gap.
        fast = (gap <= GAP_FAST) && (i_cnt_cw == last_dir);
        if (fast) begin
            streak_step = (streak == STREAK_MAX) ? STREAK_MAX : streak + SW'(1);
        end
        delta = (streak_step == STREAK_MAX) ? FAST_S : ONE_S;
        sum   = i_cnt_cw ? cur + delta : cur - delta;

        // FAST_STEP never exceeds the span, so a single correction suffices.
        if (WRAP != 0) begin
            if (sum > MAX_S) begin
                step_result = sum - SPAN_S;
            end else if (sum < MIN_S) begin
                step_result = sum + SPAN_S;
            end else begin
                step_result = sum;
            end
        end else begin
            if (sum > MAX_S) begin
                step_result = MAX_S;
            end else if (sum < MIN_S) begin
                step_result = MIN_S;
            end else begin
                step_result = sum;
            end
        end

        if (i_load) begin
            value_next  = WIDTH'(load_clamped);
            streak_next = '0;
            gap_next    = GAP_SLOW;
        end else if (i_cnt) begin
            value_next  = WIDTH'(step_result);
            streak_next = streak_step;
            gap_next    = GW'(1);
            dir_next    = i_cnt_cw;
        end
    end

    // State and output registers; all outputs come straight from flops.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            gap       <= GAP_SLOW;
            streak    <= '0;
            last_dir  <= 1'b1;
            o_value   <= RESET_V;
            o_changed <= 1'b0;
            o_at_min  <= (RESET_V == MIN_V);
            o_at_max  <= (RESET_V == MAX_V);
        end else begin
            gap       <= gap_next;
            streak    <= streak_next;
            last_dir  <= dir_next;
            o_value   <= value_next;
            o_changed <= (value_next != o_value);
            o_at_min  <= (value_next == MIN_V);
            o_at_max  <= (value_next == MAX_V);
        end
    end

endmodule

// File: tb/tb_rotary_value_accumulator.sv
// Bench for rotary_value_accumulator: a saturating instance (10..20) and a
// wrapping instance (0..9) share clock and reset. A reference model predicts
// every edge's outputs into per-instance queues; a monitor pops and compares.
module tb_rotary_value_accumulator;

    typedef struct {
        int due;
        int v;
        bit ch;
        bit at_mn;
        bit at_mx;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] cnt;
    logic [1:0] cw;
    logic [1:0] ld;
    logic [7:0] lv0;
    logic [7:0] lv1;
    logic [7:0] v0;
    logic [7:0] v1;
    logic [1:0] ch;
    logic [1:0] amn;
    logic [1:0] amx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t q_sat[$];
    exp_t q_wrap[$];

    int m_val[2];
    int m_streak[2];
    int m_last[2];
    bit m_dir[2];

    rotary_value_accumulator #(
        .WIDTH(8), .MIN(10), .MAX(20), .RESET_VALUE(10), .WRAP(0),
        .FAST_GAP(8), .ACCEL_AFTER(3), .FAST_STEP(4)
    ) dut_sat (
        .i_clk(clk), .i_reset(rst), .i_cnt(cnt[0]), .i_cnt_cw(cw[0]),
        .i_load(ld[0]), .i_load_value(lv0), .o_value(v0),
        .o_changed(ch[0]), .o_at_min(amn[0]), .o_at_max(amx[0])
    );

    rotary_value_accumulator #(
        .WIDTH(8), .MIN(0), .MAX(9), .RESET_VALUE(9), .WRAP(1),
        .FAST_GAP(8), .ACCEL_AFTER(3), .FAST_STEP(4)
    ) dut_wrap (
        .i_clk(clk), .i_reset(rst), .i_cnt(cnt[1]), .i_cnt_cw(cw[1]),
        .i_load(ld[1]), .i_load_value(lv1), .o_value(v1),
        .o_changed(ch[1]), .o_at_min(amn[1]), .o_at_max(amx[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pmin(input int i);
        return (i == 0) ? 10 : 0;
    endfunction

    function automatic int pmax(input int i);
        return (i == 0) ? 20 : 9;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_val[0] = 10;
        m_val[1] = 9;
        for (int i = 0; i < 2; i++) begin
            m_streak[i] = 0;
            m_last[i]   = -1000000;
            m_dir[i]    = 1'b1;
        end
    endtask

    // Predicts the outputs after the next edge from the behavioural rules.
    task automatic model_edge(input int i, input bit c, input bit d, input bit l, input int lvv);
        int   edge_c;
        int   old;
        int   span;
        int   nv;
        int   step;
        bit   fast;
        exp_t e;
        edge_c = cyc + 1;
        old    = m_val[i];
        span   = pmax(i) - pmin(i) + 1;
        nv     = old;
        if (l) begin
            nv = (lvv < pmin(i)) ? pmin(i) : (lvv > pmax(i)) ? pmax(i) : lvv;
            m_streak[i] = 0;
            m_last[i]   = -1000000;
        end else if (c) begin
            fast = ((edge_c - m_last[i]) <= 8) && (d == m_dir[i]);
            m_streak[i] = fast ? ((m_streak[i] >= 3) ? 3 : m_streak[i] + 1) : 0;
            step = (m_streak[i] == 3) ? 4 : 1;
            nv = d ? old + step : old - step;
            if (i == 1) begin
                if (nv > pmax(i)) nv -= span;
                else if (nv < pmin(i)) nv += span;
            end else begin
                if (nv > pmax(i)) nv = pmax(i);
                else if (nv < pmin(i)) nv = pmin(i);
            end
            m_last[i] = edge_c;
            m_dir[i]  = d;
        end
        m_val[i] = nv;
        e.due   = edge_c;
        e.v     = nv;
        e.ch    = (nv != old);
        e.at_mn = (nv == pmin(i));
        e.at_mx = (nv == pmax(i));
        if (i == 0) q_sat.push_back(e);
        else        q_wrap.push_back(e);
    endtask

    task automatic drive2(input bit c0, input bit d0, input bit l0, input int x0,
                          input bit c1, input bit d1, input bit l1, input int x1);
        @(posedge clk);
        #1;
        cnt = {c1, c0};
        cw  = {d1, d0};
        ld  = {l1, l0};
        lv0 = 8'(x0);
        lv1 = 8'(x1);
        model_edge(0, c0, d0, l0, x0);
        model_edge(1, c1, d1, l1, x1);
    endtask

    task automatic drive(input int i, input bit c, input bit d, input bit l, input int x);
        if (i == 0) drive2(c, d, l, x, 1'b0, 1'b0, 1'b0, 0);
        else        drive2(1'b0, 1'b0, 1'b0, 0, c, d, l, x);
    endtask

    task automatic idle(input int n);
        repeat (n) drive2(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Strobe followed by (space-1) idle cycles.
    task automatic strobe(input int i, input bit d, input int space);
        drive(i, 1'b1, d, 1'b0, 0);
        idle(space - 1);
    endtask

    // Monitor: compares every predicted edge once its edge has passed.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #2;
        while (q_sat.size() > 0 && q_sat[0].due <= cyc) begin
            e = q_sat.pop_front();
            check("sat_value", int'(v0), e.v);
            check("sat_changed", int'(ch[0]), int'(e.ch));
            check("sat_at_min", int'(amn[0]), int'(e.at_mn));
            check("sat_at_max", int'(amx[0]), int'(e.at_mx));
        end
        while (q_wrap.size() > 0 && q_wrap[0].due <= cyc) begin
            e = q_wrap.pop_front();
            check("wrap_value", int'(v1), e.v);
            check("wrap_changed", int'(ch[1]), int'(e.ch));
            check("wrap_at_min", int'(amn[1]), int'(e.at_mn));
            check("wrap_at_max", int'(amx[1]), int'(e.at_mx));
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cd[2];
        bit dir[2];
        bit c[2];
        bit l[2];
        int x[2];

        rst = 1'b1;
        cnt = '0;
        cw  = '0;
        ld  = '0;
        lv0 = '0;
        lv1 = '0;
        model_reset();
        #2;
        check("reset_value", int'(v0), 10);
        check("reset_at_min", int'(amn[0]), 1);
        check("reset_changed", int'(ch[0]), 0);
        check("reset_wrap_value", int'(v1), 9);
        check("reset_wrap_at_max", int'(amx[1]), 1);
        #10;
        rst = 1'b0;

        // Slow steps up then down.
        repeat (3) strobe(0, 1'b1, 20);
        check("slow_up_value", int'(v0), 13);
        repeat (3) strobe(0, 1'b0, 20);
        check("slow_down_value", int'(v0), 10);

        // Saturation at both ends and load clamping.
        drive(0, 1'b1, 1'b0, 1'b0, 0);
        idle(1);
        check("sat_low_value", int'(v0), 10);
        check("sat_low_changed", int'(ch[0]), 0);
        drive(0, 1'b0, 1'b0, 1'b1, 25);
        idle(1);
        check("load_clamp_value", int'(v0), 20);
        check("load_clamp_at_max", int'(amx[0]), 1);
        check("load_clamp_changed", int'(ch[0]), 1);
        drive(0, 1'b1, 1'b1, 1'b0, 0);
        idle(1);
        check("sat_high_changed", int'(ch[0]), 0);

        // Acceleration, then direction change drops the streak.
        drive(0, 1'b0, 1'b0, 1'b1, 10);
        idle(3);
        repeat (3) strobe(0, 1'b1, 4);
        check("accel_3_value", int'(v0), 13);
        strobe(0, 1'b1, 4);
        check("accel_4_value", int'(v0), 17);
        repeat (2) strobe(0, 1'b1, 4);
        check("accel_6_value", int'(v0), 20);
        drive(0, 1'b1, 1'b0, 1'b0, 0);
        idle(1);
        check("dir_change_value", int'(v0), 19);

        // Wrap instance.
        strobe(1, 1'b1, 2);
        check("wrap_up_value", int'(v1), 0);
        strobe(1, 1'b0, 2);
        check("wrap_down_value", int'(v1), 9);
        drive(1, 1'b0, 1'b0, 1'b1, 8);
        idle(1);
        repeat (4) strobe(1, 1'b1, 2);
        check("wrap_accel_value", int'(v1), 5);

        // Load beats a concurrent step; next step is slow.
        drive(0, 1'b1, 1'b1, 1'b1, 15);
        idle(1);
        check("load_prio_value", int'(v0), 15);
        drive(0, 1'b1, 1'b1, 1'b0, 0);
        idle(1);
        check("post_load_value", int'(v0), 16);

        // Async reset mid-streak discards the in-flight step.
        repeat (3) drive(0, 1'b1, 1'b1, 1'b0, 0);
        drive(0, 1'b1, 1'b1, 1'b0, 0);
        #2;
        rst = 1'b1;
        cnt = '0;
        ld  = '0;
        q_sat.delete();
        q_wrap.delete();
        model_reset();
        #1;
        check("async_reset_value", int'(v0), 10);
        check("async_reset_wrap_value", int'(v1), 9);
        #2;
        rst = 1'b0;
        repeat (4) strobe(0, 1'b1, 4);
        check("post_reset_accel_value", int'(v0), 17);

        // Randomised rotation on both instances.
        cd[0] = 1; cd[1] = 1; dir[0] = 1'b1; dir[1] = 1'b0;
        repeat (2000) begin
            for (int i = 0; i < 2; i++) begin
                c[i] = 1'b0;
                l[i] = 1'b0;
                x[i] = 0;
                cd[i]--;
                if (cd[i] == 0) begin
                    if ($urandom_range(0, 29) == 0) begin
                        l[i] = 1'b1;
                        x[i] = int'($urandom_range(0, 255));
                    end else begin
                        c[i] = 1'b1;
                        if ($urandom_range(0, 5) == 0) dir[i] = ~dir[i];
                    end
                    cd[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 14))
                                                        : int'($urandom_range(1, 8));
                end else if ($urandom_range(0, 15) == 0) begin
                    c[i] = 1'b0;
                    dir[i] = dir[i];
                end
            end
            drive2(c[0], dir[0] ^ ($urandom_range(0, 1) == 1 && !c[0]), l[0], x[0],
                   c[1], dir[1], l[1], x[1]);
        end
        idle(1);

        repeat (3) @(posedge clk);
        #3;
        check("sat_queue_drained", q_sat.size(), 0);
        check("wrap_queue_drained", q_wrap.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
